// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and Mem write port of the boot loader
interface prog_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream boot loader writing big-endian words to Mem; PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte
module prog_loader #(parameter int ADDR_W = 10) (
  input  logic         clk1,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_DONE
`ifdef PROG_LOADER_CKSUM_EN
    , S_CKSUM, S_ERR
`endif
  } state_t;
  state_t            r_state, w_next, w_tail;
  logic [1:0]        r_byte_cnt;
  logic [15:0]       r_count, r_word_idx;
  logic [ADDR_W-1:0] r_base, r_mem_addr;
  logic [23:0]       r_word;
  logic              r_mem_we;
  logic [31:0]       r_mem_wdata;
  logic              w_rdy, w_xfer, w_start, w_word_end, w_last, w_zero;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        r_cksum;
  assign w_tail = S_CKSUM;
  assign w_rdy  = r_state == S_HDR || r_state == S_DATA || r_state == S_CKSUM;
  assign err    = r_state == S_ERR;
`else
  assign w_tail = S_DONE;
  assign w_rdy  = r_state == S_HDR || r_state == S_DATA;
  assign err    = 1'b0;
`endif
  assign w_xfer         = bus.in_valid & w_rdy;
  assign w_start        = start & ~w_rdy;
  assign w_word_end     = r_byte_cnt == 2'd3;
  assign w_last         = r_word_idx + 16'd1 == r_count;
  assign w_zero         = {r_count[7:0], bus.in_data} == 16'd0;
  assign bus.in_ready   = w_rdy;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign busy           = w_rdy;
  assign done           = r_state == S_DONE;
  assign cpu_hold       = r_state != S_DONE;
  // state register
  always_ff @(posedge clk1)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: header/data/checksum progress gated by accepted bytes, start only when not loading
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:  if (w_xfer && w_word_end) w_next = w_zero ? w_tail : S_DATA;
      S_DATA: if (w_xfer && w_word_end && w_last) w_next = w_tail;
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: if (w_xfer) w_next = bus.in_data == r_cksum ? S_DONE : S_ERR;
`endif
      default: if (start) w_next = S_HDR;
    endcase
  end
  // datapath: header capture, word assembly, one-cycle write strobe with wrapped address
  always_ff @(posedge clk1)
    if (reset) begin
      r_byte_cnt  <= '0;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_base      <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_start) begin
        r_byte_cnt <= '0;
        r_count    <= '0;
        r_word_idx <= '0;
        r_base     <= '0;
`ifdef PROG_LOADER_CKSUM_EN
        r_cksum    <= '0;
`endif
      end else if (w_xfer) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROG_LOADER_CKSUM_EN
        r_cksum    <= r_cksum ^ bus.in_data;
`endif
        if (r_state == S_HDR && !r_byte_cnt[1]) r_base <= ADDR_W'({r_base, bus.in_data});
        if (r_state == S_HDR && r_byte_cnt[1]) r_count <= {r_count[7:0], bus.in_data};
        if (r_state == S_DATA) r_word <= {r_word[15:0], bus.in_data};
        if (r_state == S_DATA && w_word_end) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_base + r_word_idx[ADDR_W-1:0];
          r_mem_wdata <= {r_word, bus.in_data};
          r_word_idx  <= r_word_idx + 16'd1;
        end
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frame vectors plus reset/start-while-busy sequence for prog_loader
module tb_prog_loader;
  logic clk1 = 1'b0;
  logic reset, start, cpu_hold, busy, done, err;
  prog_loader_if #(.ADDR_W(10)) bus();
  prog_loader #(.ADDR_W(10)) dut (
    .clk1(clk1), .reset(reset), .start(start), .bus(bus.slave),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );
  always #5 clk1 = ~clk1;

  int n_chk = 0, n_err = 0;
  logic [9:0]  cap_a[$];
  logic [31:0] cap_d[$];
  logic [7:0]  ck;

  always @(posedge clk1)
    if (bus.mem_we) begin
      cap_a.push_back(bus.mem_addr);
      cap_d.push_back(bus.mem_wdata);
    end

  typedef struct {
    logic [15:0]      base;
    logic [15:0]      count;
    logic [2:0][31:0] w;
    bit               stall;
    bit               bad;
    logic [2:0][9:0]  ea;
    bit               edone;
    bit               eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      bus.in_valid = 1'b0;
      @(negedge clk1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ck = ck ^ b;
    n = 0;
    @(posedge clk1);
    while (!bus.in_ready && n < 40) begin
      n++;
      @(posedge clk1);
    end
    if (!bus.in_ready) chk("byte_accept_timeout", 32'(bus.in_ready), 1);
    @(negedge clk1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cap_a.delete();
    cap_d.delete();
    ck = 8'h00;
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    chk({tag, "_hold_after_start"}, 32'(cpu_hold), 1);
    chk({tag, "_done_cleared"}, 32'(done), 0);
    send_byte(v.base[15:8], v.stall);
    send_byte(v.base[7:0], v.stall);
    send_byte(v.count[15:8], v.stall);
    send_byte(v.count[7:0], v.stall);
    for (int i = 0; i < 32'(v.count); i++)
      for (int j = 3; j >= 0; j--) send_byte(v.w[i][8*j +: 8], v.stall);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(ck ^ {7'b0, v.bad}, v.stall);
`endif
    if (v.count == 16'd0) chk({tag, "_done_one_cycle_after_last"}, 32'(done), 1);
    repeat (3) @(negedge clk1);
    chk({tag, "_writes"}, 32'(cap_a.size()), 32'(v.count));
    for (int i = 0; i < 32'(v.count) && i < cap_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(cap_a[i]), 32'(v.ea[i]));
      chk($sformatf("%s_data%0d", tag, i), cap_d[i], v.w[i]);
    end
    chk({tag, "_done"}, 32'(done), 32'(v.edone));
    chk({tag, "_err"}, 32'(err), 32'(v.eerr));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!v.edone));
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  function automatic vec_t mk(input logic [15:0] base, input logic [15:0] count, input bit stall,
                              input bit bad, input logic [9:0] a0, input logic [9:0] a1,
                              input logic [9:0] a2, input bit edone, input bit eerr);
    vec_t v;
    v.base = base; v.count = count; v.stall = stall; v.bad = bad;
    v.w[0] = 32'h2801000A; v.w[1] = 32'h28020014; v.w[2] = 32'h28030019;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.edone = edone; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    vt.push_back(mk(16'h0000, 16'd3, 1'b0, 1'b0, 10'd0,    10'd1,    10'd2, 1'b1, 1'b0));
    vt.push_back(mk(16'h0000, 16'd3, 1'b1, 1'b0, 10'd0,    10'd1,    10'd2, 1'b1, 1'b0));
    vt.push_back(mk(16'h03FE, 16'd3, 1'b0, 1'b0, 10'd1022, 10'd1023, 10'd0, 1'b1, 1'b0));
    vt.push_back(mk(16'h0000, 16'd0, 1'b0, 1'b0, 10'd0,    10'd0,    10'd0, 1'b1, 1'b0));
    vt.push_back(mk(16'h1405, 16'd2, 1'b1, 1'b0, 10'd5,    10'd6,    10'd0, 1'b1, 1'b0));
`ifdef PROG_LOADER_CKSUM_EN
    vt.push_back(mk(16'h0000, 16'd3, 1'b0, 1'b1, 10'd0,    10'd1,    10'd2, 1'b0, 1'b1));
`endif
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk1);
    chk_reset("por");
    reset = 1'b0;
    @(negedge clk1);
    chk_reset("idle");
    foreach (vt[k]) run_vec(vt[k], $sformatf("vec%0d", k));
    cap_a.delete();
    cap_d.delete();
    ck = 8'h00;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h28, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h0A, 1'b0);
    send_byte(8'h28, 1'b0); send_byte(8'h02, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h14, 1'b0);
    repeat (2) @(negedge clk1);
    chk("midload_writes", 32'(cap_a.size()), 2);
    if (cap_a.size() >= 2) begin
      chk("midload_addr1", 32'(cap_a[1]), 1);
      chk("midload_data1", cap_d[1], 32'h28020014);
    end
    chk("midload_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk1);
    chk_reset("midreset");
    reset = 1'b0;
    @(negedge clk1);
    chk_reset("after_midreset");
    run_vec(vt[0], "reload");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
